// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//   Shared types for the shift arbiter: the shifter op encoding, the arbiter
//   FSM state encoding, the decoded shifter control bundle and the decode
//   function that maps an op onto the shifter's direction/fill controls.
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROL = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        HOLD  = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic left;  // 1 = shift towards the MSB
        logic sra;   // replicate the sign bit into the vacated high end
        logic sla;   // wrap A[N-1] into the vacated low end (rotate)
    } shift_ctrl_t;

    function automatic shift_ctrl_t decode_op(input shift_op_t op);
        shift_ctrl_t ctrl;
        ctrl = '0;
        case (op)
            SLL:     ctrl = '{left: 1'b1, sra: 1'b0, sla: 1'b0};
            SRL:     ctrl = '{left: 1'b0, sra: 1'b0, sla: 1'b0};
            SRA:     ctrl = '{left: 1'b0, sra: 1'b1, sla: 1'b0};
            ROL:     ctrl = '{left: 1'b1, sra: 1'b0, sla: 1'b1};
            default: ctrl = '0;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant. A lone request is always granted; when both
//   requesters ask, the one that was not granted last time wins.
//   Ports:
//     req   in  2  request vector
//     last  in  1  index of the most recently granted requester
//     en    in  1  grant enable (arbiter is able to accept this cycle)
//     grant out 2  one-hot grant, zero when disabled or no request
//     idx   out 1  index the arbiter would grant (valid when grant != 0)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant,
    output logic       idx
);

    // NOTE: every output of this always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        idx   = 1'b0;
        grant = 2'b00;
        if (req == 2'b10) begin
            idx = 1'b1;
        end else if (req == 2'b11) begin
            idx = ~last;
        end
        if (en && (req != 2'b00)) begin
            grant = idx ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//   Shares one external combinational barrel shifter between two requesters.
//   A request is granted (round-robin), latched, driven onto the shifter for
//   one ISSUE cycle, and the shifter result is registered onto a valid/ready
//   result port tagged with the requester index.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     rq_valid/rq_ready   per-requester handshake (rq_ready one-hot or zero)
//     rq_op/data/amt      per-requester op, operand and shift amount
//     sh_a/amt/left/sra/sla  shifter controls, all zero outside ISSUE
//     sh_y                shifter result (combinational from sh_*)
//     res_valid/ready     result handshake
//     res_data/res_src    result and index of the requester that issued it
//     busy                high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int N   = 8,
    parameter int SHW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          rq_valid,
    output logic [1:0]          rq_ready,
    input  logic [1:0][1:0]     rq_op,
    input  logic [1:0][N-1:0]   rq_data,
    input  logic [1:0][SHW-1:0] rq_amt,
    output logic [N-1:0]        sh_a,
    output logic [SHW-1:0]      sh_amt,
    output logic                sh_left,
    output logic                sh_sra,
    output logic                sh_sla,
    input  logic [N-1:0]        sh_y,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [N-1:0]        res_data,
    output logic                res_src,
    output logic                busy
);

    arb_state_t     state, next_state;
    logic           last;
    shift_op_t      op_q;
    logic [N-1:0]   data_q;
    logic [SHW-1:0] amt_q;
    logic           src_q;

    logic           accept_en;
    logic           accept;
    logic [1:0]     grant;
    logic           grant_idx;
    logic           in_issue;
    shift_ctrl_t    ctrl;

    // A new request can only be taken when the result register is free: in
    // IDLE, or in HOLD on the very cycle the pending result is consumed.
    // Gating with rst_n keeps a requester from seeing a grant while the
    // capture registers are held in reset.
    assign accept_en = rst_n && ((state == IDLE) || ((state == HOLD) && res_ready));

    rr_arb2 u_arb (
        .req   (rq_valid),
        .last  (last),
        .en    (accept_en),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign rq_ready = grant;
    assign accept   = |grant;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = HOLD;
            HOLD:    if (res_ready) next_state = accept ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture and result register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            op_q      <= SLL;
            data_q    <= '0;
            amt_q     <= '0;
            src_q     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_src   <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= shift_op_t'(rq_op[grant_idx]);
                data_q <= rq_data[grant_idx];
                amt_q  <= rq_amt[grant_idx];
                src_q  <= grant_idx;
                last   <= grant_idx;
            end

            if (state == ISSUE) begin
                res_data  <= sh_y;
                res_src   <= src_q;
                res_valid <= 1'b1;
            end else if ((state == HOLD) && res_ready) begin
                // Result consumed; a back-to-back request is now in flight and
                // will refill the register at the end of its ISSUE cycle.
                res_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Shifter drive: only live during ISSUE so the shared datapath sees
    // quiet inputs otherwise.
    // -------------------------------------------------------------------------
    assign in_issue = (state == ISSUE);
    assign ctrl     = decode_op(op_q);

    assign sh_a    = in_issue ? data_q : '0;
    assign sh_amt  = in_issue ? amt_q  : '0;
    assign sh_left = in_issue & ctrl.left;
    assign sh_sra  = in_issue & ctrl.sra;
    assign sh_sla  = in_issue & ctrl.sla;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//   Scoreboard bench for shift_arbiter. Requests are queued per requester; a
//   grant watcher moves the hand-computed expected result of each granted
//   request into the scoreboard, and a separate monitor pops and compares on
//   every result handshake. Directed checks cover reset, latency, shifter
//   drive, back-pressure and reset during ISSUE.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;
    import shift_pkg::*;

    localparam int N   = 8;
    localparam int SHW = 3;

    logic                clk;
    logic                rst_n;
    logic [1:0]          rq_valid;
    logic [1:0]          rq_ready;
    logic [1:0][1:0]     rq_op;
    logic [1:0][N-1:0]   rq_data;
    logic [1:0][SHW-1:0] rq_amt;
    logic [N-1:0]        sh_a;
    logic [SHW-1:0]      sh_amt;
    logic                sh_left;
    logic                sh_sra;
    logic                sh_sla;
    logic [N-1:0]        sh_y;
    logic                res_valid;
    logic                res_ready;
    logic [N-1:0]        res_data;
    logic                res_src;
    logic                busy;

    shift_arbiter #(.N(N), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rq_valid  (rq_valid),
        .rq_ready  (rq_ready),
        .rq_op     (rq_op),
        .rq_data   (rq_data),
        .rq_amt    (rq_amt),
        .sh_a      (sh_a),
        .sh_amt    (sh_amt),
        .sh_left   (sh_left),
        .sh_sra    (sh_sra),
        .sh_sla    (sh_sla),
        .sh_y      (sh_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_src   (res_src),
        .busy      (busy)
    );

    // External shifter datapath
    always_comb begin
        if (sh_left) begin
            if (sh_sla) sh_y = (sh_a << sh_amt) | (sh_a >> (N - int'(sh_amt)));
            else        sh_y = sh_a << sh_amt;
        end else begin
            if (sh_sra) sh_y = $signed(sh_a) >>> sh_amt;
            else        sh_y = sh_a >> sh_amt;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        shift_op_t      op;
        logic [N-1:0]   data;
        logic [SHW-1:0] amt;
        logic [N-1:0]   exp;
    } req_t;

    typedef struct {
        logic [N-1:0] data;
        logic         src;
    } res_t;

    req_t q0[$];
    req_t q1[$];
    res_t sb[$];
    bit   grant_log[$];
    int   hs_cycles[$];
    bit   model_last = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Driver: present the head of each requester queue just after the edge.
    initial begin
        rq_valid = 2'b00;
        rq_op    = '0;
        rq_data  = '0;
        rq_amt   = '0;
        forever begin
            @(posedge clk);
            #1;
            rq_valid[0] = (q0.size() > 0);
            rq_valid[1] = (q1.size() > 0);
            if (q0.size() > 0) begin
                rq_op[0] = q0[0].op; rq_data[0] = q0[0].data; rq_amt[0] = q0[0].amt;
            end
            if (q1.size() > 0) begin
                rq_op[1] = q1[0].op; rq_data[1] = q1[0].data; rq_amt[1] = q1[0].amt;
            end
        end
    end

    // Grant watcher: check arbitration against the round-robin model and
    // move the expected result of the granted request into the scoreboard.
    always @(negedge clk) begin
        bit exp_idx;
        bit got_idx;
        if (rst_n) begin
            if (rq_valid != 2'b00) check("ready_not_both", 32'(rq_ready == 2'b11), 32'd0);
            if (res_valid && !res_ready && rq_valid != 2'b00)
                check("ready_under_backpressure", 32'(rq_ready), 32'd0);
            if (rq_ready != 2'b00) begin
                exp_idx = (rq_valid == 2'b11) ? ~model_last : rq_valid[1];
                got_idx = rq_ready[1];
                check("grant_idx", 32'(got_idx), 32'(exp_idx));
                grant_log.push_back(got_idx);
                model_last = exp_idx;
                if (!got_idx && q0.size() > 0) begin
                    sb.push_back('{q0[0].exp, 1'b0});
                    void'(q0.pop_front());
                end else if (got_idx && q1.size() > 0) begin
                    sb.push_back('{q1[0].exp, 1'b1});
                    void'(q1.pop_front());
                end else begin
                    fail_event("grant_without_request");
                end
            end
        end
    end

    // Monitor: compare every result handshake against the scoreboard and
    // check the result stays frozen while stalled.
    always @(negedge clk) begin
        static logic [N-1:0] prev_data  = '0;
        static logic         prev_src   = 1'b0;
        static bit           prev_stall = 1'b0;
        res_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_data", 32'(res_data), 32'(prev_data));
                check("hold_src", 32'(res_src), 32'(prev_src));
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    fail_event("unexpected_result");
                end else begin
                    e = sb.pop_front();
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_src", 32'(res_src), 32'(e.src));
                    hs_cycles.push_back(cyc);
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            prev_src   = res_src;
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() > 0 || q1.size() > 0 || sb.size() > 0) fail_event({name, "_drain_timeout"});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        res_ready = 1'b1;

        // Reset values
        #2;
        check("rst_rq_ready", 32'(rq_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_src", 32'(res_src), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sh_ctrl", 32'({sh_a, sh_amt, sh_left, sh_sra, sh_sla}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: r0 SRA 0x90 by 3 -> 0xF2, accepted same cycle, valid two later
        @(negedge clk);
        q0.push_back('{SRA, 8'h90, 3'd3, 8'hF2});
        @(negedge clk);
        check("t1_ready_same_cycle", 32'(rq_ready), 32'b01);
        @(negedge clk);
        check("t1_issue_res_valid", 32'(res_valid), 32'd0);
        check("t1_issue_busy", 32'(busy), 32'd1);
        check("t1_sh_a", 32'(sh_a), 32'h90);
        check("t1_sh_amt", 32'(sh_amt), 32'd3);
        check("t1_sh_dir_fill", 32'({sh_left, sh_sra, sh_sla}), 32'b010);
        @(negedge clk);
        check("t1_res_valid", 32'(res_valid), 32'd1);
        check("t1_res_data", 32'(res_data), 32'hF2);
        check("t1_res_src", 32'(res_src), 32'd0);
        wait_drain("t1");

        // 2: r1 back-to-back stream, one result every 2 cycles
        hs_cycles.delete();
        q1.push_back('{SRL, 8'h90, 3'd3, 8'h12});
        q1.push_back('{SLL, 8'h81, 3'd1, 8'h02});
        q1.push_back('{ROL, 8'h81, 3'd1, 8'h03});
        wait_drain("t2");
        check("t2_result_count", 32'(hs_cycles.size()), 32'd3);
        if (hs_cycles.size() == 3) begin
            check("t2_interval_a", 32'(hs_cycles[1] - hs_cycles[0]), 32'd2);
            check("t2_interval_b", 32'(hs_cycles[2] - hs_cycles[1]), 32'd2);
        end

        // 3: both requesters continuously valid -> grants alternate 0,1,0,1
        grant_log.delete();
        q0.push_back('{SLL, 8'h01, 3'd1, 8'h02});
        q0.push_back('{SRA, 8'h80, 3'd7, 8'hFF});
        q1.push_back('{SRL, 8'h80, 3'd1, 8'h40});
        q1.push_back('{ROL, 8'h80, 3'd1, 8'h01});
        wait_drain("t3");
        check("t3_grant_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check("t3_grant_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}),
                  32'b0101);
        end

        // 4: back-pressure for 5 cycles, then r1 accepted on the handshake
        @(posedge clk);
        #2;
        res_ready = 1'b0;
        @(negedge clk);
        q0.push_back('{SLL, 8'h0F, 3'd4, 8'hF0});
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) fail_event("t4_result_timeout");
        q1.push_back('{SRL, 8'hF0, 3'd4, 8'h0F});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_data", 32'(res_data), 32'hF0);
            check("t4_stall_src", 32'(res_src), 32'd0);
            check("t4_stall_ready", 32'(rq_ready), 32'd0);
        end
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        @(negedge clk);
        check("t4_r1_accept_on_handshake", 32'(rq_ready), 32'b10);
        wait_drain("t4");

        // 5: amount 0 leaves the operand untouched for every op
        q0.push_back('{SLL, 8'hA5, 3'd0, 8'hA5});
        q0.push_back('{SRL, 8'hA5, 3'd0, 8'hA5});
        q0.push_back('{SRA, 8'hA5, 3'd0, 8'hA5});
        q0.push_back('{ROL, 8'hA5, 3'd0, 8'hA5});
        wait_drain("t5");

        // 6: reset during ISSUE discards the request
        grant_log.delete();
        q0.push_back('{SRL, 8'h55, 3'd1, 8'h2A});
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (grant_log.size() == 0) fail_event("t6_grant_timeout");
        @(posedge clk);
        #2;
        check("t6_in_issue", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_last = 1'b1;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_res_valid", 32'(res_valid), 32'd0);
        check("t6_rst_sh_a", 32'(sh_a), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t6_no_result", 32'(res_valid), 32'd0);
        end
        rst_n = 1'b1;
        grant_log.delete();
        q0.push_back('{SLL, 8'h01, 3'd2, 8'h04});
        q1.push_back('{SRL, 8'h40, 3'd2, 8'h10});
        wait_drain("t6");
        check("t6_grant_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() > 0) check("t6_last_reset_r0_first", 32'(grant_log[0]), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
